// File: rtl/dsp_result_collector.sv
// Collects DSP results: realigns the compare_res strobe to the programmed output delay, tags each result
// with its mode and buffers it in a FIFO behind a valid/ready stream. Optional DSP_COLLECT_STATS_EN adds capture/drop counters.
module dsp_result_collector #(
  parameter int WIDTH         = 16,
  parameter int PIPELINE_BITS = 3,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             compare_res,
  input  logic [2*WIDTH-1:0]               dsp_out,
  input  logic [1:0]                       mode,
  input  logic [PIPELINE_BITS-1:0]         pipe_stages,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [2*WIDTH-1:0]               res_data,
  output logic [1:0]                       res_mode,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
  output logic                             overflow,
  input  logic                             clr_overflow
`ifdef DSP_COLLECT_STATS_EN
  ,
  output logic [15:0]                      cap_cnt,
  output logic [15:0]                      drop_cnt
`endif
);

  localparam int DW = 2 * WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // Handshake: a result transfers on every rising edge where res_valid and res_ready are both 1;
  // res_valid never drops and the head never changes while res_ready is 0.

  logic [2:0]               stage [PIPELINE_BITS];
  logic [PIPELINE_BITS-1:0] pipe_reg;
  logic                     cap_v;
  logic [1:0]               cap_mode;

  logic [DW+1:0]            mem [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [AW-1:0]            rd_ptr_next;
  logic [CW-1:0]            count;
  logic [CW-1:0]            count_next;
  logic [DW+1:0]            wr_entry;
  logic [DW+1:0]            head_next;
  logic                     full;
  logic                     rd;
  logic                     wr;
  logic                     drop;

  // A zero delay bypasses the alignment stages; delays beyond the stage count never fire.
  always_comb begin
    cap_v    = 1'b0;
    cap_mode = 2'b00;
    if (pipe_stages == '0) begin
      cap_v    = compare_res;
      cap_mode = mode;
    end else begin
      for (int i = 0; i < PIPELINE_BITS; i++) begin
        if (pipe_reg == PIPELINE_BITS'(i + 1)) begin
          cap_v    = stage[i][2];
          cap_mode = stage[i][1:0];
        end
      end
    end
  end

  assign full     = (count == CW'(FIFO_DEPTH));
  assign rd       = res_valid & res_ready;
  assign wr       = cap_v & (~full | rd);
  assign drop     = cap_v & full & ~rd;
  assign wr_entry = {dsp_out, cap_mode};

  always_comb begin
    count_next = count;
    case ({wr, rd})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
    rd_ptr_next = rd ? rd_ptr + AW'(1) : rd_ptr;
    // The entry written this edge may itself become the new head.
    head_next = (wr && (wr_ptr == rd_ptr_next)) ? wr_entry : mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPELINE_BITS; i++) begin
        stage[i] <= 3'b000;
      end
      pipe_reg  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_mode  <= 2'b00;
    end else begin
      stage[0] <= {compare_res, mode};
      for (int i = 1; i < PIPELINE_BITS; i++) begin
        stage[i] <= stage[i-1];
      end
      pipe_reg  <= pipe_stages;
      if (wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr    <= rd_ptr_next;
      count     <= count_next;
      res_valid <= (count_next != '0);
      if (count_next != '0) begin
        {res_data, res_mode} <= head_next;
      end
      overflow  <= drop | (overflow & ~clr_overflow);
    end
  end

  assign fifo_count = count;

`ifdef DSP_COLLECT_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n || clr_overflow) begin
      cap_cnt  <= 16'h0000;
      drop_cnt <= 16'h0000;
    end else begin
      if (wr && (cap_cnt != 16'hFFFF)) begin
        cap_cnt <= cap_cnt + 16'h0001;
      end
      if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dsp_result_collector.sv
// Bench for dsp_result_collector: directed scenarios plus randomized traffic, checked against a queue-based
// reference model; a separate monitor pops expected results as the DUT hands them out.
module tb_dsp_result_collector;

  localparam int WIDTH = 16;
  localparam int PB    = 3;
  localparam int DEPTH = 8;
  localparam int DW    = 2 * WIDTH;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int W     = DW + 2;

  logic          clk;
  logic          rst_n;
  logic          compare_res;
  logic [DW-1:0] dsp_out;
  logic [1:0]    mode;
  logic [PB-1:0] pipe_stages;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [1:0]    res_mode;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          clr_overflow;
`ifdef DSP_COLLECT_STATS_EN
  logic [15:0]   cap_cnt;
  logic [15:0]   drop_cnt;
`endif

  dsp_result_collector #(.WIDTH(WIDTH), .PIPELINE_BITS(PB), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .compare_res  (compare_res),
    .dsp_out      (dsp_out),
    .mode         (mode),
    .pipe_stages  (pipe_stages),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_mode     (res_mode),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`ifdef DSP_COLLECT_STATS_EN
    ,
    .cap_cnt      (cap_cnt),
    .drop_cnt     (drop_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       v;
    logic [1:0] m;
  } hist_t;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_q[$];
  hist_t        hist[$];
  logic         model_ovf  = 1'b0;
  int           model_cap  = 0;
  int           model_drop = 0;
  bit           model_live = 1'b0;

  // Each falling edge: compare DUT state to the model, then predict the coming rising edge.
  always @(negedge clk) begin
    hist_t cur;
    hist_t sel;
    int    k;
    bit    mrd;
    bit    mfull;
    bit    mdrop;
    if (model_live) begin
      check("fifo_count", 64'(fifo_count), 64'(model_q.size()));
      check("overflow", 64'(overflow), 64'(model_ovf));
      check("res_valid", 64'(res_valid), 64'(model_q.size() != 0));
`ifdef DSP_COLLECT_STATS_EN
      check("cap_cnt", 64'(cap_cnt), 64'(model_cap));
      check("drop_cnt", 64'(drop_cnt), 64'(model_drop));
`endif
    end
    if (!rst_n) begin
      model_q.delete();
      exp_q.delete();
      hist.delete();
      for (int i = 0; i < PB; i++) hist.push_back('0);
      model_ovf  = 1'b0;
      model_cap  = 0;
      model_drop = 0;
      model_live = 1'b1;
    end else if (model_live) begin
      k     = int'(pipe_stages);
      cur.v = compare_res;
      cur.m = mode;
      if (k == 0)       sel = cur;
      else if (k <= PB) sel = hist[k-1];
      else              sel = '0;
      mrd   = (model_q.size() != 0) && res_ready;
      mfull = (model_q.size() == DEPTH);
      mdrop = 1'b0;
      if (mrd) void'(model_q.pop_front());
      if (sel.v) begin
        if (!mfull || mrd) begin
          model_q.push_back({dsp_out, sel.m});
          exp_q.push_back({dsp_out, sel.m});
          if (model_cap < 65535) model_cap++;
        end else begin
          mdrop = 1'b1;
          if (model_drop < 65535) model_drop++;
        end
      end
      if (mdrop)             model_ovf = 1'b1;
      else if (clr_overflow) model_ovf = 1'b0;
      if (clr_overflow) begin
        model_cap  = 0;
        model_drop = 0;
      end
      hist.push_front(cur);
      void'(hist.pop_back());
    end
  end

  // ---------------- scoreboard monitor ----------------
  bit           prev_hold = 1'b0;
  logic [W-1:0] prev_head = '0;

  always @(negedge clk) begin
    logic [W-1:0] exp_item;
    if (rst_n && res_valid) begin
      if (prev_hold) check("head_hold", 64'({res_data, res_mode}), 64'(prev_head));
      if (res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=%0h required=none", {res_data, res_mode});
        end else begin
          exp_item = exp_q.pop_front();
          check("res_data_mode", 64'({res_data, res_mode}), 64'(exp_item));
        end
      end
    end
    prev_hold = rst_n && res_valid && !res_ready;
    prev_head = {res_data, res_mode};
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [DW-1:0] d);
    compare_res = v;
    mode        = m;
    dsp_out     = d;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'($urandom_range(0, 3)), $urandom);
  endtask

  task automatic set_pipe(input int k);
    idle(PB + 2);
    pipe_stages = PB'(k);
    idle(PB + 2);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    checks++;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    summary();
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int ready_pct;
    int pipes[6];
    pipes = '{0, 1, 2, 3, 5, 7};
    rst_n        = 1'b0;
    compare_res  = 1'b0;
    dsp_out      = '0;
    mode         = 2'b00;
    pipe_stages  = '0;
    res_ready    = 1'b1;
    clr_overflow = 1'b0;
    repeat (3) step();
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_res_data", 64'(res_data), 64'(0));
    check("rst_res_mode", 64'(res_mode), 64'(0));
    check("rst_fifo_count", 64'(fifo_count), 64'(0));
    rst_n = 1'b1;
    idle(2);

    // zero delay: captured this cycle, visible next cycle for one cycle
    drive(1'b1, 2'b10, 32'h0000_0019);
    check("p0_valid", 64'(res_valid), 64'(1));
    check("p0_data", 64'(res_data), 64'h19);
    check("p0_mode", 64'(res_mode), 64'(2));
    idle(1);
    check("p0_valid_drop", 64'(res_valid), 64'(0));

    // three-cycle delay: strobe at t, data at t+3
    set_pipe(3);
    drive(1'b1, 2'b01, $urandom);
    drive(1'b0, 2'b00, $urandom);
    drive(1'b0, 2'b00, $urandom);
    check("p3_not_yet", 64'(res_valid), 64'(0));
    drive(1'b0, 2'b00, 32'hFFFF_FFF6);
    check("p3_valid", 64'(res_valid), 64'(1));
    check("p3_data", 64'(res_data), 64'hFFFF_FFF6);
    check("p3_mode", 64'(res_mode), 64'(1));
    idle(2);

    // fill, overflow, clear, full read+write, drain
    set_pipe(0);
    res_ready = 1'b0;
    for (int i = 1; i <= 8; i++) drive(1'b1, 2'($urandom_range(0, 3)), DW'(i));
    check("full_count", 64'(fifo_count), 64'(8));
    check("full_no_ovf", 64'(overflow), 64'(0));
    drive(1'b1, 2'b11, DW'(9));
    check("ovf_set", 64'(overflow), 64'(1));
    check("ovf_count", 64'(fifo_count), 64'(8));
    clr_overflow = 1'b1;
    idle(1);
    clr_overflow = 1'b0;
    check("ovf_cleared", 64'(overflow), 64'(0));
    res_ready = 1'b1;
    drive(1'b1, 2'b11, DW'(10));
    res_ready = 1'b0;
    check("rw_full_count", 64'(fifo_count), 64'(8));
    check("rw_full_no_ovf", 64'(overflow), 64'(0));
    check("rw_full_head", 64'(res_data), 64'(2));
    idle(3);
    res_ready = 1'b1;
    idle(DEPTH + 2);
    check("drained", 64'(exp_q.size()), 64'(0));

    // delay beyond the alignment stages never captures
    set_pipe(5);
    for (int i = 0; i < 6; i++) drive(1'b1, 2'b01, $urandom);
    idle(PB + 2);
    check("p5_count", 64'(fifo_count), 64'(0));

    // reset with results buffered and strobes in flight
    set_pipe(2);
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, 2'($urandom_range(0, 3)), $urandom);
    pulse_reset();
    check("mid_rst_valid", 64'(res_valid), 64'(0));
    check("mid_rst_count", 64'(fifo_count), 64'(0));
    check("mid_rst_ovf", 64'(overflow), 64'(0));
`ifdef DSP_COLLECT_STATS_EN
    check("mid_rst_cap_cnt", 64'(cap_cnt), 64'(0));
`endif
    idle(PB + 2);
    check("mid_rst_lost", 64'(fifo_count), 64'(0));
    res_ready = 1'b1;

    // randomized traffic across delays and backpressure levels
    for (int r = 0; r < 12; r++) begin
      set_pipe(pipes[$urandom_range(0, 5)]);
      ready_pct = $urandom_range(10, 100);
      for (int c = 0; c < 120; c++) begin
        res_ready    = ($urandom_range(1, 100) <= ready_pct);
        clr_overflow = ($urandom_range(0, 15) == 0);
        drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
      end
      clr_overflow = 1'b0;
      if (r == 6) pulse_reset();
    end

    res_ready = 1'b1;
    idle(DEPTH + PB + 6);
    check("final_drain", 64'(exp_q.size()), 64'(0));
    check("final_empty", 64'(res_valid), 64'(0));
    summary();
    $finish;
  end

endmodule
